// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch sequencer.
//   fetch_state_e        - sequencer state encoding (3-bit)
//   DEFAULT_RESET_DELAY  - idle cycles after reset release before the first request
//   DEFAULT_ACK_TIMEOUT  - unacknowledged request cycles tolerated before error
//   DELAY_CNT_W          - counter width covering RESET_DELAY up to 15
//   TIMEOUT_CNT_W        - counter width covering ACK_TIMEOUT up to 255
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    HOLD    = 3'd2,
    DISCARD = 3'd3,
    ERROR   = 3'd4
  } fetch_state_e;

  localparam int DEFAULT_RESET_DELAY = 2;
  localparam int DEFAULT_ACK_TIMEOUT = 15;
  localparam int DELAY_CNT_W         = 4;
  localparam int TIMEOUT_CNT_W       = 8;

endpackage

// File: rtl/cycle_counter.sv
// cycle_counter: free-running up counter with synchronous clear.
//   clk       in   clock
//   Reset     in   synchronous active-low reset
//   i_clear   in   force the count to zero this edge (wins over i_enable)
//   i_enable  in   advance the count by one this edge
//   o_count   out  current count
module cycle_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             i_clear,
  input  logic             i_enable,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!Reset || i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: sequences instruction fetches and program-counter strobes.
//   clk           in   clock
//   Reset         in   synchronous active-low reset
//   imemAck       in   memory accepted the request; instrIn valid this cycle
//   instrIn       in   instruction word from memory
//   stall         in   decode cannot take the held instruction
//   branchTaken   in   taken-branch pulse from execute
//   branchOffset  in   offset paired with branchTaken
//   imemReq       out  fetch request
//   instrValid    out  instrOut holds a live instruction
//   instrOut      out  captured instruction
//   pcUpdate      out  PC loads its next value
//   pcBranch      out  PC load takes the branch path
//   pcOffset      out  last branch offset
//   flush         out  held instruction was squashed
//   fetchError    out  sticky acknowledge timeout
// All outputs are registered.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int RESET_DELAY = DEFAULT_RESET_DELAY,
  parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        imemAck,
  input  logic [31:0] instrIn,
  input  logic        stall,
  input  logic        branchTaken,
  input  logic [23:0] branchOffset,
  output logic        imemReq,
  output logic        instrValid,
  output logic [31:0] instrOut,
  output logic        pcUpdate,
  output logic        pcBranch,
  output logic [23:0] pcOffset,
  output logic        flush,
  output logic        fetchError
);

  fetch_state_e r_state, w_state_next;

  logic        r_imemReq, r_instrValid, r_pcUpdate, r_pcBranch, r_flush, r_fetchError;
  logic [31:0] r_instrOut;
  logic [23:0] r_pcOffset;

  logic        w_req_next, w_valid_next, w_pcu_next, w_pcb_next, w_flush_next, w_err_next;
  logic [31:0] w_instr_next;
  logic [23:0] w_off_next;

  logic [DELAY_CNT_W-1:0]   w_delay_count;
  logic [TIMEOUT_CNT_W-1:0] w_to_count;
  logic w_delay_done, w_timeout_hit, w_to_clear, w_to_enable;

  cycle_counter #(.WIDTH(DELAY_CNT_W)) u_delay_cnt (
    .clk      (clk),
    .Reset    (Reset),
    .i_clear  (r_state != IDLE),
    .i_enable (r_state == IDLE),
    .o_count  (w_delay_count)
  );

  // The timeout restarts whenever a fresh wait begins (entering FETCH or
  // DISCARD) and on every acknowledge; it only advances while a request waits.
  assign w_to_enable = r_imemReq && !imemAck;
  assign w_to_clear  = imemAck ||
                       ((w_state_next != r_state) &&
                        (w_state_next == FETCH || w_state_next == DISCARD));

  cycle_counter #(.WIDTH(TIMEOUT_CNT_W)) u_timeout_cnt (
    .clk      (clk),
    .Reset    (Reset),
    .i_clear  (w_to_clear),
    .i_enable (w_to_enable),
    .o_count  (w_to_count)
  );

  assign w_delay_done  = (w_delay_count == DELAY_CNT_W'(RESET_DELAY));
  // This edge would be the ACK_TIMEOUT-th unacknowledged request cycle.
  assign w_timeout_hit = w_to_enable && (w_to_count == TIMEOUT_CNT_W'(ACK_TIMEOUT - 1));

  always_comb begin
    // NOTE: every next value gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    w_state_next = r_state;
    w_req_next   = 1'b0;
    w_valid_next = 1'b0;
    w_instr_next = r_instrOut;
    w_pcu_next   = 1'b0;
    w_pcb_next   = 1'b0;
    w_off_next   = r_pcOffset;
    w_flush_next = 1'b0;
    w_err_next   = r_fetchError;

    unique case (r_state)
      IDLE: begin
        if (w_delay_done) begin
          w_state_next = FETCH;
          w_req_next   = 1'b1;
        end
      end

      FETCH: begin
        w_req_next = 1'b1;
        if (w_timeout_hit) begin
          w_state_next = ERROR;
          w_req_next   = 1'b0;
          w_err_next   = 1'b1;
        end else if (branchTaken) begin
          // A word returned alongside the branch is from the old path: drop it.
          w_pcu_next   = 1'b1;
          w_pcb_next   = 1'b1;
          w_off_next   = branchOffset;
          w_state_next = imemAck ? FETCH : DISCARD;
        end else if (imemAck) begin
          w_instr_next = instrIn;
          w_valid_next = 1'b1;
          w_pcu_next   = 1'b1;
          w_req_next   = 1'b0;
          w_state_next = HOLD;
        end
      end

      HOLD: begin
        w_valid_next = 1'b1;
        if (branchTaken) begin
          w_pcu_next   = 1'b1;
          w_pcb_next   = 1'b1;
          w_off_next   = branchOffset;
          w_flush_next = 1'b1;
          w_valid_next = 1'b0;
          w_req_next   = 1'b1;
          w_state_next = FETCH;
        end else if (!stall) begin
          w_valid_next = 1'b0;
          w_req_next   = 1'b1;
          w_state_next = FETCH;
        end
      end

      DISCARD: begin
        // Keep requesting until the stale access retires; its data is ignored.
        w_req_next = 1'b1;
        if (w_timeout_hit) begin
          w_state_next = ERROR;
          w_req_next   = 1'b0;
          w_err_next   = 1'b1;
        end else begin
          if (branchTaken) begin
            w_pcu_next = 1'b1;
            w_pcb_next = 1'b1;
            w_off_next = branchOffset;
          end
          if (imemAck) begin
            w_state_next = FETCH;
          end
        end
      end

      ERROR: begin
        w_state_next = ERROR;
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      r_state      <= IDLE;
      r_imemReq    <= 1'b0;
      r_instrValid <= 1'b0;
      r_instrOut   <= '0;
      r_pcUpdate   <= 1'b0;
      r_pcBranch   <= 1'b0;
      r_pcOffset   <= '0;
      r_flush      <= 1'b0;
      r_fetchError <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_imemReq    <= w_req_next;
      r_instrValid <= w_valid_next;
      r_instrOut   <= w_instr_next;
      r_pcUpdate   <= w_pcu_next;
      r_pcBranch   <= w_pcb_next;
      r_pcOffset   <= w_off_next;
      r_flush      <= w_flush_next;
      r_fetchError <= w_err_next;
    end
  end

  assign imemReq    = r_imemReq;
  assign instrValid = r_instrValid;
  assign instrOut   = r_instrOut;
  assign pcUpdate   = r_pcUpdate;
  assign pcBranch   = r_pcBranch;
  assign pcOffset   = r_pcOffset;
  assign flush      = r_flush;
  assign fetchError = r_fetchError;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scenarios plus randomized traffic, every cycle
// compared against a behavioural model of the fetch protocol.
module tb_fetch_sequencer;

  localparam int RESET_DELAY = 2;
  localparam int ACK_TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        Reset = 1'b0;
  logic        imemAck = 1'b0;
  logic [31:0] instrIn = '0;
  logic        stall = 1'b0;
  logic        branchTaken = 1'b0;
  logic [23:0] branchOffset = '0;
  logic        imemReq, instrValid, pcUpdate, pcBranch, flush, fetchError;
  logic [31:0] instrOut;
  logic [23:0] pcOffset;

  fetch_sequencer #(.RESET_DELAY(RESET_DELAY), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk          (clk),
    .Reset        (Reset),
    .imemAck      (imemAck),
    .instrIn      (instrIn),
    .stall        (stall),
    .branchTaken  (branchTaken),
    .branchOffset (branchOffset),
    .imemReq      (imemReq),
    .instrValid   (instrValid),
    .instrOut     (instrOut),
    .pcUpdate     (pcUpdate),
    .pcBranch     (pcBranch),
    .pcOffset     (pcOffset),
    .flush        (flush),
    .fetchError   (fetchError)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: the sequencer is either waiting out the post-reset delay, waiting
  // on memory (possibly for a squashed access), holding an instruction, or dead.
  bit          m_started, m_hold, m_squash, m_dead;
  int          m_idle, m_age;
  logic        e_req, e_valid, e_pcu, e_pcb, e_flush, e_err;
  logic [31:0] e_instr;
  logic [23:0] e_off;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (!Reset) begin
      m_started = 0; m_hold = 0; m_squash = 0; m_dead = 0; m_idle = 0; m_age = 0;
      e_req = 0; e_valid = 0; e_instr = '0; e_pcu = 0; e_pcb = 0; e_off = '0;
      e_flush = 0; e_err = 0;
    end else begin
      e_pcu = 0; e_pcb = 0; e_flush = 0;
      if (m_dead) begin
        e_req = 0; e_valid = 0;
      end else if (!m_started) begin
        if (m_idle == RESET_DELAY) begin
          m_started = 1; e_req = 1; m_age = 0;
        end else begin
          m_idle++;
        end
      end else if (m_hold) begin
        if (branchTaken) begin
          e_pcu = 1; e_pcb = 1; e_off = branchOffset; e_flush = 1;
          m_hold = 0; e_valid = 0; e_req = 1; m_age = 0;
        end else if (!stall) begin
          m_hold = 0; e_valid = 0; e_req = 1; m_age = 0;
        end
      end else begin
        if (!imemAck && m_age + 1 == ACK_TIMEOUT) begin
          m_dead = 1; e_err = 1; e_req = 0;
        end else begin
          m_age = imemAck ? 0 : m_age + 1;
          if (branchTaken) begin
            e_pcu = 1; e_pcb = 1; e_off = branchOffset;
          end
          if (m_squash) begin
            if (imemAck) m_squash = 0;
          end else if (branchTaken) begin
            if (!imemAck) begin
              m_squash = 1; m_age = 0;
            end
          end else if (imemAck) begin
            e_instr = instrIn; e_valid = 1; e_pcu = 1; m_hold = 1; e_req = 0;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    check("imemReq",    imemReq,    e_req);
    check("instrValid", instrValid, e_valid);
    check("instrOut",   instrOut,   e_instr);
    check("pcUpdate",   pcUpdate,   e_pcu);
    check("pcBranch",   pcBranch,   e_pcb);
    check("pcOffset",   pcOffset,   e_off);
    check("flush",      flush,      e_flush);
    check("fetchError", fetchError, e_err);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic wait_req(input int budget);
    int n = 0;
    while (imemReq !== 1'b1 && n < budget) begin
      cycle();
      n++;
    end
    check("wait_req_bound", imemReq, 1'b1);
  endtask

  task automatic pulse_reset();
    Reset = 1'b0;
    cycle();
    check("rst_imemReq",    imemReq,    1'b0);
    check("rst_instrValid", instrValid, 1'b0);
    check("rst_instrOut",   instrOut,   32'h0);
    check("rst_pcUpdate",   pcUpdate,   1'b0);
    check("rst_pcBranch",   pcBranch,   1'b0);
    check("rst_pcOffset",   pcOffset,   24'h0);
    check("rst_flush",      flush,      1'b0);
    check("rst_fetchError", fetchError, 1'b0);
    Reset = 1'b1;
  endtask

  initial begin
    int first_req, pcu_cnt, last_pcu, valid_cnt, req_cnt, req_cycles;
    logic [31:0] held;

    // Zero-wait streaming from reset release.
    imemAck = 1'b1; stall = 1'b0; instrIn = 32'hE3A00001;
    cycle();
    pulse_reset();
    first_req = 0; pcu_cnt = 0; last_pcu = 0;
    for (int c = 1; c <= 12; c++) begin
      cycle();
      if (imemReq === 1'b1 && first_req == 0) first_req = c;
      if (pcUpdate === 1'b1) begin
        if (last_pcu != 0) check("pcu_spacing", c - last_pcu, 2);
        last_pcu = c;
        pcu_cnt++;
      end
    end
    check("first_req_cycle", first_req, RESET_DELAY + 1);
    check("stream_pcu_count", pcu_cnt, 5);
    check("stream_instrOut", instrOut, 32'hE3A00001);

    // Ack followed by a three-cycle stall.
    imemAck = 1'b0;
    pulse_reset();
    wait_req(20);
    instrIn = 32'hA5A5_0F0F; imemAck = 1'b1; stall = 1'b1;
    cycle();
    imemAck = 1'b0;
    valid_cnt = (instrValid === 1'b1) ? 1 : 0;
    pcu_cnt   = (pcUpdate === 1'b1) ? 1 : 0;
    req_cnt   = (imemReq === 1'b1) ? 1 : 0;
    for (int k = 0; k < 3; k++) begin
      instrIn = $urandom;
      cycle();
      check("stall_instrOut", instrOut, 32'hA5A5_0F0F);
      if (instrValid === 1'b1) valid_cnt++;
      if (pcUpdate === 1'b1) pcu_cnt++;
      if (imemReq === 1'b1) req_cnt++;
    end
    stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      if (instrValid === 1'b1) valid_cnt++;
      if (pcUpdate === 1'b1) pcu_cnt++;
    end
    check("stall_valid_cycles", valid_cnt, 4);
    check("stall_pcu_count", pcu_cnt, 1);
    check("stall_req_count", req_cnt, 0);

    // Branch while holding a stalled instruction.
    instrIn = 32'h1234_5678; imemAck = 1'b1; stall = 1'b1;
    cycle();
    imemAck = 1'b0;
    cycle();
    branchTaken = 1'b1; branchOffset = 24'h000010;
    cycle();
    branchTaken = 1'b0; branchOffset = 24'hFFFFFF;
    check("hold_br_flush", flush, 1'b1);
    check("hold_br_pcUpdate", pcUpdate, 1'b1);
    check("hold_br_pcBranch", pcBranch, 1'b1);
    check("hold_br_pcOffset", pcOffset, 24'h000010);
    check("hold_br_valid", instrValid, 1'b0);
    check("hold_br_req", imemReq, 1'b1);
    cycle();
    check("hold_br_flush_done", flush, 1'b0);
    check("hold_br_pcu_done", pcUpdate, 1'b0);
    check("hold_br_offset_kept", pcOffset, 24'h000010);
    stall = 1'b0;

    // Branch during an outstanding fetch; the late word must be discarded.
    branchTaken = 1'b1; branchOffset = 24'h000ABC;
    cycle();
    branchTaken = 1'b0;
    pcu_cnt   = (pcUpdate === 1'b1) ? 1 : 0;
    valid_cnt = (instrValid === 1'b1) ? 1 : 0;
    check("disc_req_held", imemReq, 1'b1);
    for (int k = 0; k < 6; k++) begin
      imemAck = (k == 2);
      instrIn = (k == 2) ? 32'hDEADBEEF : 32'h0;
      cycle();
      if (pcUpdate === 1'b1) pcu_cnt++;
      if (instrValid === 1'b1) valid_cnt++;
    end
    imemAck = 1'b0;
    check("disc_pcu_count", pcu_cnt, 1);
    check("disc_valid_count", valid_cnt, 0);
    check("disc_instrOut", instrOut, 32'h1234_5678);
    check("disc_pcOffset", pcOffset, 24'h000ABC);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      Reset        = ($urandom_range(0, 199) != 0);
      imemAck      = $urandom_range(0, 1) == 1;
      stall        = $urandom_range(0, 9) < 4;
      branchTaken  = $urandom_range(0, 9) == 0;
      branchOffset = 24'($urandom);
      instrIn      = $urandom;
      cycle();
    end
    branchTaken = 1'b0; imemAck = 1'b0; stall = 1'b0; Reset = 1'b1;

    // Acknowledge never arrives.
    pulse_reset();
    wait_req(20);
    req_cycles = 1;
    for (int k = 0; k < 40 && fetchError !== 1'b1; k++) begin
      cycle();
      if (imemReq === 1'b1) req_cycles++;
    end
    check("to_req_cycles", req_cycles, ACK_TIMEOUT);
    check("to_fetchError", fetchError, 1'b1);
    check("to_req_dropped", imemReq, 1'b0);
    for (int k = 0; k < 4; k++) begin
      imemAck = $urandom_range(0, 1) == 1;
      branchTaken = (k == 1);
      branchOffset = 24'h00BEEF;
      cycle();
      check("err_sticky", fetchError, 1'b1);
      check("err_no_pcu", pcUpdate, 1'b0);
    end
    branchTaken = 1'b0; imemAck = 1'b0;
    pulse_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Controller that sequences the program counter and the instruction-memory fetch handshake for the single-issue ARM core. It issues fetch requests, captures returned instructions, holds them under decode stall, and produces the update-enable and branch-select strobes that drive the program counter register. A taken branch from execute redirects the program counter and squashes in-flight or held fetches; a missing memory acknowledge raises a sticky error.

## Interface
- RESET_DELAY, 2: idle cycles after reset release before the first request (1..15)
- ACK_TIMEOUT, 15: cycles `imemReq` may stay unacknowledged before error (1..255)
- clk  in  1  clock, all state updates on posedge
- Reset  in  1  synchronous, active-low reset; sampled on posedge clk
- imemAck  in  1  memory accepted request; `instrIn` valid in the same cycle
- instrIn  in  32  instruction word from memory
- stall  in  1  decode cannot accept the held instruction this cycle
- branchTaken  in  1  execute resolved a taken branch (single-cycle pulse)
- branchOffset  in  24  offset paired with `branchTaken`
- imemReq  out  1  fetch request, registered
- instrValid  out  1  `instrOut` holds a live instruction, registered
- instrOut  out  32  captured instruction, registered
- pcUpdate  out  1  program counter loads its next value this edge, registered
- pcBranch  out  1  select branch path for that load; only meaningful with `pcUpdate`
- pcOffset  out  24  branch offset forwarded to the program counter
- flush  out  1  one-cycle pulse: held instruction was squashed
- fetchError  out  1  sticky acknowledge-timeout flag

## Operation
- States: IDLE, FETCH, HOLD, DISCARD, ERROR.
- Reset low: state IDLE, all outputs 0, `instrOut` = 0, counters 0. Reset overrides every state, including mid-handshake; an outstanding request is dropped without waiting for its ack.
- IDLE: count RESET_DELAY cycles, then FETCH. `branchTaken` ignored.
- FETCH: `imemReq` = 1. On `imemAck`: `instrOut` <= `instrIn`, `instrValid` <= 1, one-cycle `pcUpdate` (`pcBranch` = 0), go HOLD.
- HOLD: `imemReq` = 0, `instrValid` = 1. `stall` = 0 at an edge: instruction consumed, `instrValid` <= 0, go FETCH. `stall` = 1: hold `instrOut` unchanged.
- `branchTaken` in FETCH/HOLD/DISCARD: `pcUpdate` = `pcBranch` = 1 for one cycle, `pcOffset` <= `branchOffset`.
- Branch in HOLD: `instrValid` <= 0, `flush` pulse, go FETCH. Branch wins over `stall`.
- Branch in FETCH without ack: request outstanding; go DISCARD.
- Branch in FETCH with ack same cycle: returned word dropped (`instrValid` stays 0), only the branch `pcUpdate` issued, go FETCH.
- DISCARD: `imemReq` = 1 until ack; data ignored, no `pcUpdate`; then FETCH. A further branch in DISCARD updates `pcOffset` and issues `pcUpdate`/`pcBranch`; state stays DISCARD.
- Timeout counter: clears on entering FETCH/DISCARD and on every ack. It increments each cycle `imemReq` is high without ack. On reaching ACK_TIMEOUT: `fetchError` <= 1, `imemReq` <= 0, go ERROR.
- ERROR: all strobes 0, `instrValid` 0. Exit only via reset.
- At most one `pcUpdate` per cycle. `pcOffset` keeps its last value when no branch occurs.

## Timing
- All outputs registered; input events at edge N appear on outputs after edge N.
- First `imemReq` rises RESET_DELAY+1 cycles after the first edge with Reset high.
- Ack at edge N: `instrValid` and `pcUpdate` high during cycle N+1; `pcUpdate` low at N+2.
- Peak throughput: one instruction per 2 cycles (FETCH, HOLD) with zero-wait memory and no stall.
- Branch to redirected request: `pcUpdate`/`pcBranch` in cycle N+1 and `imemReq` high in cycle N+1 (from FETCH/HOLD), or after the pending ack (from DISCARD).

## Structure
- Shared package `fetch_pkg`: state enum (IDLE=0, FETCH=1, HOLD=2, DISCARD=3, ERROR=4, 3-bit), default RESET_DELAY/ACK_TIMEOUT constants.
- Sub-module `cycle_counter` (parameter WIDTH; clear, enable, count out), instantiated twice: reset delay and ack timeout.

## Test plan
- Reset release, `imemAck` tied 1, `stall` 0, `instrIn` = 0xE3A00001: `imemReq` rises cycle 3; `pcUpdate` pulses every 2 cycles; `instrOut` = 0xE3A00001.
- Ack with `stall` held 3 cycles: `instrValid` high 4 cycles, one `pcUpdate`, `instrOut` stable, no new `imemReq` until stall drops.
- `branchTaken` with offset 0x000010 in HOLD while stalled: `flush` pulse, `pcUpdate`=`pcBranch`=1 once, `pcOffset` = 0x000010, `instrValid` 0 next cycle.
- Branch in FETCH, ack 3 cycles later with 0xDEADBEEF: DISCARD entered, `instrValid` never high for that word, exactly one `pcUpdate` (branch).
- `imemAck` held 0: `fetchError` set after 15 request cycles, `imemReq` drops, state ERROR; Reset low one edge clears all outputs to 0.
